sram_access_ctrl: RTL and testbench
===================================

// Module: sram_access_ctrl
// PURPOSE
//  Request-side sequencer that sits directly upstream of testing_sram and is its only driver.
//  - Accepts single-byte read/write requests over a valid/ready handshake.
//  - Drives the SRAM strobes (read, write, addr, valueIn, dump, dumpNum) with fixed-length pulses.
//  - Captures valueOut and returns it with a one-cycle done pulse.
//  - Guarantees the SRAM never sees read and write high together, and sees no strobe glitches.
// PARAMETERS
//  ADDR_W       16  address width; matches the SRAM addr port
//  DATA_W       8   data width; matches SRAM valueIn/valueOut
//  READ_CYCLES  2   clocks sram_read is held high; must be >= 1
//  WRITE_CYCLES 1   clocks sram_write is held high; must be >= 1
// PORTS
//  clk            in   1       system clock, rising edge
//  n_rst          in   1       asynchronous active-low reset
//  req_valid      in   1       request present
//  req_ready      out  1       controller can accept; high only in IDLE
//  req_write      in   1       1 = write, 0 = read
//  req_addr       in   ADDR_W  request address
//  req_wdata      in   DATA_W  write data
//  done           out  1       one-cycle pulse: access complete
//  rsp_rdata      out  DATA_W  read data; valid while done is high after a read, held otherwise
//  dump_req       in   1       level request to dump SRAM contents
//  dump_num       in   1       dump file select
//  sram_read      out  1       to SRAM read
//  sram_write     out  1       to SRAM write
//  sram_addr      out  ADDR_W  to SRAM addr
//  sram_wdata     out  DATA_W  to SRAM valueIn
//  sram_dump      out  1       to SRAM dump
//  sram_dump_num  out  1       to SRAM dumpNum
//  sram_rdata     in   DATA_W  from SRAM valueOut
// BEHAVIOUR
//  - Reset: every output is 0 except req_ready.
//    - req_ready is 1 because the state is IDLE.
//    - The cycle counter is cleared.
//  - States: IDLE, WRITE, READ, DUMP. Every SRAM-facing output is registered.
//  - IDLE, on an edge with req_valid && req_ready:
//    - Latch addr, wdata and write into the sram_addr and sram_wdata registers.
//    - Go to WRITE or READ, setting the matching strobe and loading the counter.
//  - IDLE, with dump_req && !req_valid:
//    - Go to DUMP and set sram_dump=1.
//    - sram_dump_num is loaded with dump_num.
//  - req_valid has priority over dump_req. A dump_req that is still high is served at the next IDLE.
//  - WRITE: sram_write stays high for exactly WRITE_CYCLES clocks, then drops.
//  - READ: sram_read stays high for exactly READ_CYCLES clocks.
//    - rsp_rdata captures sram_rdata on the edge that ends the last read cycle.
//  - DUMP: sram_dump is high for exactly 1 clock.
//  - Every exit from WRITE, READ or DUMP returns to IDLE. In that cycle:
//    - done=1 (done does not pulse for a dump).
//    - req_ready=1.
//  - Latency with request accepted at edge T:
//    - Strobe is high in cycles T+1 .. T+N, where N = READ_CYCLES or WRITE_CYCLES.
//    - done is high in cycle T+N+1.
//  - Back-to-back:
//    - A request accepted while done is high starts its strobe one cycle later.
//    - Therefore at least one cycle with both strobes low always separates accesses.
//  - sram_addr and sram_wdata hold their last values while idle. They change only on accept.
//  - rsp_rdata is unchanged by writes.
//  - No backpressure on done. The consumer must sample it in its pulse cycle.
//  - Reset mid-access:
//    - Strobes drop asynchronously and no done is issued.
//    - The in-flight request is discarded and never replayed.
//  - Address range: the full ADDR_W range is legal. No wrap logic is needed; the address passes through.
// CONFIGURATION
//  SRAM_ACCESS_STATS_EN
//  - Defined:
//    - Adds outputs rd_count and wr_count, 16 bits each.
//    - Each counts completed accesses, increments in the done cycle, and saturates at 16'hFFFF.
//    - Both clear on reset and on stats_clr, an added 1-bit input. Clear wins over a simultaneous increment.
//  - Undefined: those ports and counters are absent. Behaviour is otherwise identical.
// TESTING
//  1. Write 89@0, 210@59, 66@195; read 0, 59, 195.
//     -> rsp_rdata 89, 210, 66 with done; sram_write high 1 clock each, sram_read high 2 clocks each.
//  2. Hold req_valid high across a write to 59 then a read of 59.
//     -> req_ready low during the strobes; exactly one gap cycle; read returns 210.
//  3. Raise dump_req and req_valid in the same IDLE cycle with dump_num=0.
//     -> the access runs first, then sram_dump pulses 1 clock with sram_dump_num=0 and no done.
//  4. Assert n_rst low in the first sram_read cycle of a read of 195.
//     -> sram_read drops immediately, done never pulses, req_ready=1 after release.
//  5. Write to addr 16'hFFFF with data 8'hA5, then read it back.
//     -> sram_addr=16'hFFFF and rsp_rdata=8'hA5.
//  6. With SRAM_ACCESS_STATS_EN: do 3 writes and 2 reads, then pulse stats_clr.
//     -> wr_count=3, rd_count=2, then both 0.

Source files
------------

// File: rtl/sram_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_access_ctrl_if
// Description : Request/response and SRAM strobe bundle for sram_access_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_access_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              done;
    logic [DATA_W-1:0] rsp_rdata;
    logic              dump_req;
    logic              dump_num;
    logic              sram_read;
    logic              sram_write;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_dump;
    logic              sram_dump_num;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, dump_req, dump_num, sram_rdata,
        output req_ready, done, rsp_rdata, sram_read, sram_write, sram_addr, sram_wdata,
               sram_dump, sram_dump_num
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, dump_req, dump_num, sram_rdata,
        input  req_ready, done, rsp_rdata, sram_read, sram_write, sram_addr, sram_wdata,
               sram_dump, sram_dump_num
    );
endinterface
`default_nettype wire

// File: rtl/sram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_access_ctrl
// Description : Single-driver request sequencer for testing_sram with fixed
//               strobe lengths; SRAM_ACCESS_STATS_EN adds access counters.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_access_ctrl #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               n_rst,
`ifdef SRAM_ACCESS_STATS_EN
    input  logic               stats_clr,
    output logic [15:0]        rd_count,
    output logic [15:0]        wr_count,
`endif
    sram_access_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DUMP  = 2'd3
    } state_t;

    localparam int MAX_CYC = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_CYCLES - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              rd_q, rd_nxt;
    logic              wr_q, wr_nxt;
    logic              dump_q, dump_nxt;
    logic              dnum_q, dnum_nxt;
    logic              done_q, done_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic [DATA_W-1:0] rdata_q, rdata_nxt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            dump_q  <= 1'b0;
            dnum_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rd_q    <= rd_nxt;
            wr_q    <= wr_nxt;
            dump_q  <= dump_nxt;
            dnum_q  <= dnum_nxt;
            done_q  <= done_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            rdata_q <= rdata_nxt;
        end
    end

    // Strobes default low each cycle, so every exit edge lands in IDLE with
    // both strobes cleared; that idle cycle is the guaranteed access gap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        dump_nxt  = 1'b0;
        done_nxt  = 1'b0;
        dnum_nxt  = dnum_q;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        rdata_nxt = rdata_q;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_nxt  = bus.req_addr;
                    wdata_nxt = bus.req_wdata;
                    if (bus.req_write) begin
                        state_nxt = WRITE;
                        wr_nxt    = 1'b1;
                        cnt_nxt   = WR_LOAD;
                    end else begin
                        state_nxt = READ;
                        rd_nxt    = 1'b1;
                        cnt_nxt   = RD_LOAD;
                    end
                end else if (bus.dump_req) begin
                    state_nxt = DUMP;
                    dump_nxt  = 1'b1;
                    dnum_nxt  = bus.dump_num;
                end
            end
            WRITE: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    wr_nxt  = 1'b1;
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            READ: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    rdata_nxt = bus.sram_rdata;
                end else begin
                    rd_nxt  = 1'b1;
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DUMP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.req_ready     = (state == IDLE);
    assign bus.done          = done_q;
    assign bus.rsp_rdata     = rdata_q;
    assign bus.sram_read     = rd_q;
    assign bus.sram_write    = wr_q;
    assign bus.sram_addr     = addr_q;
    assign bus.sram_wdata    = wdata_q;
    assign bus.sram_dump     = dump_q;
    assign bus.sram_dump_num = dnum_q;

`ifdef SRAM_ACCESS_STATS_EN
    logic        rd_exit;
    logic        wr_exit;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    // Counting on the exit edge makes the new total visible in the done cycle.
    assign rd_exit = (state == READ)  && (cnt == '0);
    assign wr_exit = (state == WRITE) && (cnt == '0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_cnt <= 16'd0;
            wr_cnt <= 16'd0;
        end else if (stats_clr) begin
            rd_cnt <= 16'd0;
            wr_cnt <= 16'd0;
        end else begin
            if (rd_exit && (rd_cnt != 16'hFFFF)) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
            if (wr_exit && (wr_cnt != 16'hFFFF)) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end

    assign rd_count = rd_cnt;
    assign wr_count = wr_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_access_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for sram_access_ctrl: timeline reference model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_sram_access_ctrl;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int RC     = 2;
    localparam int WC     = 1;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    sram_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef SRAM_ACCESS_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    sram_access_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_CYCLES(RC), .WRITE_CYCLES(WC)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
`ifdef SRAM_ACCESS_STATS_EN
        .stats_clr(stats_clr),
        .rd_count (rd_count),
        .wr_count (wr_count),
`endif
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // SRAM stand-in: combinational read, write on a strobed edge
    logic [7:0] stub_mem [0:65535];
    logic [7:0] ref_mem  [0:65535];
    always @(posedge clk) if (bus.sram_write) stub_mem[bus.sram_addr] <= bus.sram_wdata;
    assign bus.sram_rdata = stub_mem[bus.sram_addr];

    // Timeline model: an accepted access books its strobe, done and data cycles
    int         cyc = 0;
    int         free_at = 0;
    bit         exp_rd   [int];
    bit         exp_wr   [int];
    bit         exp_done [int];
    bit         exp_dump [int];
    int         done_kind[int];
    logic [7:0] rsp_at   [int];
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wdata = '0;
    logic [7:0]  m_rsp = '0;
    logic        m_dnum = 1'b0;
`ifdef SRAM_ACCESS_STATS_EN
    int m_rdc = 0, m_wrc = 0;
    bit clr_pend = 1'b0;
`endif

    always @(negedge clk) begin : p_model
        bit ready;
        int n;
        if (!n_rst) begin
            chk("rst_ready", bus.req_ready, 1);
            chk("rst_outs", {bus.done, bus.sram_read, bus.sram_write, bus.sram_dump,
                             bus.sram_dump_num, bus.rsp_rdata, bus.sram_wdata}, 0);
            chk("rst_addr", bus.sram_addr, 0);
            exp_rd.delete(); exp_wr.delete(); exp_done.delete(); exp_dump.delete();
            done_kind.delete(); rsp_at.delete();
            free_at = cyc + 1;
            m_addr = '0; m_wdata = '0; m_rsp = '0; m_dnum = 1'b0;
`ifdef SRAM_ACCESS_STATS_EN
            m_rdc = 0; m_wrc = 0; clr_pend = 1'b0;
            chk("rst_counts", {rd_count, wr_count}, 0);
`endif
        end else begin
            if (rsp_at.exists(cyc)) m_rsp = rsp_at[cyc];
            ready = (cyc >= free_at);
            chk("req_ready",  bus.req_ready,     ready);
            chk("sram_read",  bus.sram_read,     exp_rd.exists(cyc));
            chk("sram_write", bus.sram_write,    exp_wr.exists(cyc));
            chk("done",       bus.done,          exp_done.exists(cyc));
            chk("sram_dump",  bus.sram_dump,     exp_dump.exists(cyc));
            chk("dump_num",   bus.sram_dump_num, m_dnum);
            chk("sram_addr",  bus.sram_addr,     m_addr);
            chk("sram_wdata", bus.sram_wdata,    m_wdata);
            chk("rsp_rdata",  bus.rsp_rdata,     m_rsp);
`ifdef SRAM_ACCESS_STATS_EN
            if (clr_pend) begin
                m_rdc = 0; m_wrc = 0;
            end else if (done_kind.exists(cyc)) begin
                if (done_kind[cyc] == 1 && m_rdc < 65535) m_rdc++;
                if (done_kind[cyc] == 2 && m_wrc < 65535) m_wrc++;
            end
            chk("rd_count", rd_count, m_rdc);
            chk("wr_count", wr_count, m_wrc);
            clr_pend = stats_clr;
`endif
            if (ready && bus.req_valid) begin
                n = bus.req_write ? WC : RC;
                for (int k = 1; k <= n; k++) begin
                    if (bus.req_write) exp_wr[cyc + k] = 1'b1;
                    else               exp_rd[cyc + k] = 1'b1;
                end
                exp_done[cyc + n + 1]  = 1'b1;
                done_kind[cyc + n + 1] = bus.req_write ? 2 : 1;
                free_at = cyc + n + 1;
                m_addr  = bus.req_addr;
                m_wdata = bus.req_wdata;
                if (bus.req_write) ref_mem[bus.req_addr] = bus.req_wdata;
                else               rsp_at[cyc + n + 1] = ref_mem[bus.req_addr];
            end else if (ready && bus.dump_req) begin
                exp_dump[cyc + 1] = 1'b1;
                free_at = cyc + 2;
                m_dnum  = bus.dump_num;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic access(input bit wr, input logic [15:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int len);
        int n;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = d;
        n = 0;
        while (!bus.req_ready && n < 50) begin step(); n++; end
        if (n >= 50) chk("accept_timeout", 1, 0);
        step();
        bus.req_valid = 1'b0;
        len = 0; n = 0;
        while (!bus.done && n < 50) begin
            len += int'(bus.sram_read | bus.sram_write);
            step(); n++;
        end
        if (n >= 50) chk("done_timeout", 1, 0);
        rd = bus.rsp_rdata;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.done && n < 50) begin step(); n++; end
        if (n >= 50) chk(name, 1, 0);
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return 16'd0;
            1:       return 16'd59;
            2:       return 16'd195;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    logic [7:0] rd;
    int         len;

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : p_drive
        for (int i = 0; i < 65536; i++) begin stub_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.dump_req = 1'b0; bus.dump_num = 1'b0;
        repeat (3) step();
        n_rst = 1'b1;
        step();

        // Writes then reads at three addresses
        access(1'b1, 16'd0,   8'd89,  rd, len); chk("wr0_len", len, 1);
        access(1'b1, 16'd59,  8'd210, rd, len); chk("wr59_len", len, 1);
        access(1'b1, 16'd195, 8'd66,  rd, len); chk("wr195_len", len, 1);
        chk("rsp_after_writes", rd, 0);
        access(1'b0, 16'd0,   8'd0, rd, len); chk("rd0", rd, 89);  chk("rd0_len", len, 2);
        access(1'b0, 16'd59,  8'd0, rd, len); chk("rd59", rd, 210); chk("rd59_len", len, 2);
        access(1'b0, 16'd195, 8'd0, rd, len); chk("rd195", rd, 66); chk("rd195_len", len, 2);

        // Back-to-back with req_valid held high
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 16'd59; bus.req_wdata = 8'd210;
        step();
        chk("b2b_wr_strobe", bus.sram_write, 1);
        chk("b2b_ready_low", bus.req_ready, 0);
        bus.req_write = 1'b0;
        wait_done("b2b_wr_done_timeout");
        chk("b2b_gap", {bus.sram_read, bus.sram_write}, 2'b00);
        step();
        bus.req_valid = 1'b0;
        chk("b2b_rd_start", bus.sram_read, 1);
        wait_done("b2b_rd_done_timeout");
        chk("b2b_rd_data", bus.rsp_rdata, 210);
        step();

        // Standalone dump with file 1
        bus.dump_req = 1'b1; bus.dump_num = 1'b1;
        step();
        bus.dump_req = 1'b0;
        chk("dump1_pulse", {bus.sram_dump, bus.sram_dump_num}, 2'b11);
        step();
        chk("dump1_end", {bus.sram_dump, bus.done}, 2'b00);

        // Dump and access raised together: access first
        bus.dump_req = 1'b1; bus.dump_num = 1'b0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 16'd0;
        step();
        bus.req_valid = 1'b0;
        chk("prio_read_first", {bus.sram_read, bus.sram_dump}, 2'b10);
        wait_done("prio_done_timeout");
        chk("prio_no_dump_yet", bus.sram_dump, 0);
        step();
        bus.dump_req = 1'b0;
        chk("prio_dump", {bus.sram_dump, bus.sram_dump_num, bus.done}, 3'b100);
        step();
        chk("prio_dump_end", {bus.sram_dump, bus.done}, 2'b00);

        // Reset during the first read cycle
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 16'd195;
        step();
        chk("rst_mid_read_on", bus.sram_read, 1);
        n_rst = 1'b0;
        #1;
        chk("rst_mid_read_off", bus.sram_read, 0);
        bus.req_valid = 1'b0;
        step(); step();
        n_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("rst_no_done", {bus.done, bus.req_ready}, 2'b01);
            step();
        end

        // Top of the address range
        access(1'b1, 16'hFFFF, 8'hA5, rd, len);
        chk("max_addr", bus.sram_addr, 16'hFFFF);
        access(1'b0, 16'hFFFF, 8'h00, rd, len);
        chk("max_rdata", rd, 8'hA5);

`ifdef SRAM_ACCESS_STATS_EN
        stats_clr = 1'b1; step(); stats_clr = 1'b0;
        access(1'b1, 16'd10, 8'd1, rd, len);
        access(1'b1, 16'd11, 8'd2, rd, len);
        access(1'b1, 16'd12, 8'd3, rd, len);
        access(1'b0, 16'd10, 8'd0, rd, len);
        access(1'b0, 16'd11, 8'd0, rd, len);
        chk("stats_wr", wr_count, 3);
        chk("stats_rd", rd_count, 2);
        stats_clr = 1'b1; step(); stats_clr = 1'b0;
        chk("stats_clr", {rd_count, wr_count}, 0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.req_valid = ($urandom_range(0, 2) == 0);
            bus.req_write = $urandom_range(0, 1) == 1;
            bus.req_addr  = pick_addr();
            bus.req_wdata = 8'($urandom);
            bus.dump_req  = ($urandom_range(0, 7) == 0);
            bus.dump_num  = $urandom_range(0, 1) == 1;
`ifdef SRAM_ACCESS_STATS_EN
            stats_clr = ($urandom_range(0, 49) == 0);
`endif
            step();
        end
        bus.req_valid = 1'b0; bus.dump_req = 1'b0;
`ifdef SRAM_ACCESS_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
